// File: rtl/m_mc_ctrl.sv
// m_mc_ctrl: multicycle IF/ID/EX/MA/WB sequencer for the m_proc5 datapath.
// Optional macro M_MC_CTRL_SKIP_MA_EN: non-load/store instructions go EX->WB directly.
module m_mc_ctrl #(
  parameter int HALT_REG   = 30,
  parameter int WAIT_LIMIT = 16
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_run,
  input  logic [4:0] w_opcode5,
  input  logic [4:0] w_rd,
  input  logic       w_tkn,
  input  logic       w_imem_rdy,
  input  logic       w_dmem_rdy,
  output logic [2:0] w_state,
  output logic       w_imem_req,
  output logic       w_ir_we,
  output logic       w_dmem_req,
  output logic       w_dmem_we,
  output logic       w_rf_we,
  output logic       w_wb_sel,
  output logic       w_pc_we,
  output logic       w_pc_sel,
  output logic       w_retire,
  output logic       w_halt,
  output logic       w_err
);

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MA   = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [4:0] OP_S  = 5'b01000;
  localparam logic [4:0] OP_B  = 5'b11000;
  localparam logic [4:0] OP_LD = 5'b00000;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [4:0]    op_q;
  logic [4:0]    rd_q;
  logic          r_tkn;
  logic          err_q;
  logic [CW-1:0] wait_cnt;
  logic          is_ld;
  logic          is_s;
  logic          is_b;
  logic          is_mem;
  logic          wb_rf_we;
  logic          waiting;
  logic          wd_hit;

  assign is_ld    = (op_q == OP_LD);
  assign is_s     = (op_q == OP_S);
  assign is_b     = (op_q == OP_B);
  assign is_mem   = is_ld || is_s;
  assign wb_rf_we = !is_s && !is_b;

  // A cycle counts as waiting only while a memory handshake is actually pending.
  assign waiting = ((state == ST_IF) && w_run && !w_imem_rdy) ||
                   ((state == ST_MA) && is_mem && !w_dmem_rdy);
  assign wd_hit  = (WAIT_LIMIT != 0) && waiting && (wait_cnt == LIMIT_M1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IF:   if (w_run && w_imem_rdy) state_nxt = ST_ID;
      ST_ID:   state_nxt = ST_EX;
`ifdef M_MC_CTRL_SKIP_MA_EN
      ST_EX:   state_nxt = is_mem ? ST_MA : ST_WB;
`else
      ST_EX:   state_nxt = ST_MA;
`endif
      ST_MA:   if (!is_mem || w_dmem_rdy) state_nxt = ST_WB;
      ST_WB:   state_nxt = (wb_rf_we && (rd_q == 5'(HALT_REG))) ? ST_HALT : ST_IF;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IF;
    endcase
    if (wd_hit) state_nxt = ST_HALT;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state    <= ST_IF;
      op_q     <= '0;
      rd_q     <= '0;
      r_tkn    <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ID) begin
        op_q <= w_opcode5;
        rd_q <= w_rd;
      end
      if (state == ST_EX) r_tkn <= is_b && w_tkn;
      if (wd_hit) err_q <= 1'b1;
      if (waiting && (state_nxt == state)) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Outputs are gated by the reset input so nothing can pulse while reset is held.
  always_comb begin
    w_state    = 3'd0;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_retire   = 1'b0;
    w_halt     = 1'b0;
    w_err      = 1'b0;
    if (w_rst_n) begin
      w_state = state;
      w_err   = err_q;
      case (state)
        ST_IF: begin
          w_imem_req = w_run;
          w_ir_we    = w_run && w_imem_rdy;
        end
        ST_MA: begin
          w_dmem_req = is_mem;
          w_dmem_we  = is_s;
          w_wb_sel   = is_ld;
        end
        ST_WB: begin
          w_rf_we  = wb_rf_we;
          w_wb_sel = is_ld;
          w_pc_we  = 1'b1;
          w_pc_sel = r_tkn;
          w_retire = 1'b1;
        end
        ST_HALT: w_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Self-checking bench for m_mc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against an instruction-level behavioural model.
module tb_m_mc_ctrl;

  localparam int HALT_REG   = 30;
  localparam int WAIT_LIMIT = 16;
`ifdef M_MC_CTRL_SKIP_MA_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [4:0] OP_R  = 5'b01100;
  localparam logic [4:0] OP_S  = 5'b01000;
  localparam logic [4:0] OP_B  = 5'b11000;
  localparam logic [4:0] OP_U1 = 5'b00101;
  localparam logic [4:0] OP_U2 = 5'b01101;
  localparam logic [4:0] OP_J  = 5'b11011;
  localparam logic [4:0] OP_LD = 5'b00000;
  localparam logic [4:0] OP_I  = 5'b00100;

  logic       w_clk = 1'b0;
  logic       w_rst_n = 1'b0;
  logic       w_run = 1'b0;
  logic [4:0] w_opcode5 = '0;
  logic [4:0] w_rd = '0;
  logic       w_tkn = 1'b0;
  logic       w_imem_rdy = 1'b0;
  logic       w_dmem_rdy = 1'b0;

  logic [2:0] w_state;
  logic w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_rf_we, w_wb_sel;
  logic w_pc_we, w_pc_sel, w_retire, w_halt, w_err;

  logic [2:0] z_state;
  logic z_imem_req, z_ir_we, z_dmem_req, z_dmem_we, z_rf_we, z_wb_sel;
  logic z_pc_we, z_pc_sel, z_retire, z_halt, z_err;

  int checks = 0;
  int failures = 0;

  logic [4:0] op_tbl [8] = '{OP_R, OP_S, OP_B, OP_U1, OP_U2, OP_J, OP_LD, OP_I};

  m_mc_ctrl #(.HALT_REG(HALT_REG), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_run(w_run), .w_opcode5(w_opcode5),
    .w_rd(w_rd), .w_tkn(w_tkn), .w_imem_rdy(w_imem_rdy), .w_dmem_rdy(w_dmem_rdy),
    .w_state(w_state), .w_imem_req(w_imem_req), .w_ir_we(w_ir_we),
    .w_dmem_req(w_dmem_req), .w_dmem_we(w_dmem_we), .w_rf_we(w_rf_we),
    .w_wb_sel(w_wb_sel), .w_pc_we(w_pc_we), .w_pc_sel(w_pc_sel),
    .w_retire(w_retire), .w_halt(w_halt), .w_err(w_err)
  );

  // Watchdog-disabled instance shares the stimulus; only examined in the stall scenario.
  m_mc_ctrl #(.HALT_REG(HALT_REG), .WAIT_LIMIT(0)) dut0 (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_run(w_run), .w_opcode5(w_opcode5),
    .w_rd(w_rd), .w_tkn(w_tkn), .w_imem_rdy(w_imem_rdy), .w_dmem_rdy(w_dmem_rdy),
    .w_state(z_state), .w_imem_req(z_imem_req), .w_ir_we(z_ir_we),
    .w_dmem_req(z_dmem_req), .w_dmem_we(z_dmem_we), .w_rf_we(z_rf_we),
    .w_wb_sel(z_wb_sel), .w_pc_we(z_pc_we), .w_pc_sel(z_pc_sel),
    .w_retire(z_retire), .w_halt(z_halt), .w_err(z_err)
  );

  always #5 w_clk = ~w_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic [4:0] op, input logic [4:0] rd,
                               input logic tkn, input logic irdy, input logic drdy);
    w_run = run; w_opcode5 = op; w_rd = rd; w_tkn = tkn; w_imem_rdy = irdy; w_dmem_rdy = drdy;
  endtask

  task automatic step;
    @(posedge w_clk);
    #1;
  endtask

  task automatic doReset;
    w_rst_n = 1'b0;
    step();
    step();
    w_rst_n = 1'b1;
  endtask

  // Instruction-level model: stage numbers are the visible w_state codes.
  int         m_stage = 0;
  int         m_wait = 0;
  logic [4:0] m_op = '0;
  logic [4:0] m_rd = '0;
  bit         m_tkn = 1'b0;
  bit         m_err = 1'b0;

  function automatic bit isMem(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_S);
  endfunction

  always @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      m_stage = 0; m_wait = 0; m_op = '0; m_rd = '0; m_tkn = 1'b0; m_err = 1'b0;
    end else begin
      int prev;
      bit stalled;
      prev = m_stage;
      stalled = (m_stage == 0 && w_run && !w_imem_rdy) ||
                (m_stage == 3 && isMem(m_op) && !w_dmem_rdy);
      m_wait = stalled ? m_wait + 1 : 0;
      if (WAIT_LIMIT != 0 && m_wait >= WAIT_LIMIT) begin
        m_err = 1'b1;
        m_stage = 5;
      end else begin
        case (m_stage)
          0: if (w_run && w_imem_rdy) m_stage = 1;
          1: begin m_op = w_opcode5; m_rd = w_rd; m_stage = 2; end
          2: begin
            m_tkn = (m_op == OP_B) && w_tkn;
            m_stage = (SKIP && !isMem(m_op)) ? 4 : 3;
          end
          3: if (!isMem(m_op) || w_dmem_rdy) m_stage = 4;
          4: m_stage = (m_op != OP_S && m_op != OP_B && m_rd == 5'(HALT_REG)) ? 5 : 0;
          default: m_stage = 5;
        endcase
      end
      if (m_stage != prev) m_wait = 0;
    end
  end

  always @(negedge w_clk) begin
    logic [2:0] e_state;
    logic e_imem_req, e_ir_we, e_dmem_req, e_dmem_we, e_rf_we, e_wb_sel;
    logic e_pc_we, e_pc_sel, e_retire, e_halt, e_err;
    e_state = '0; e_imem_req = 0; e_ir_we = 0; e_dmem_req = 0; e_dmem_we = 0; e_rf_we = 0;
    e_wb_sel = 0; e_pc_we = 0; e_pc_sel = 0; e_retire = 0; e_halt = 0; e_err = 0;
    if (w_rst_n) begin
      e_state = 3'(m_stage);
      e_err = m_err;
      case (m_stage)
        0: begin e_imem_req = w_run; e_ir_we = w_run && w_imem_rdy; end
        3: begin
          e_dmem_req = isMem(m_op);
          e_dmem_we  = (m_op == OP_S);
          e_wb_sel   = (m_op == OP_LD);
        end
        4: begin
          e_rf_we = (m_op != OP_S) && (m_op != OP_B);
          e_wb_sel = (m_op == OP_LD);
          e_pc_we = 1; e_pc_sel = m_tkn; e_retire = 1;
        end
        5: e_halt = 1;
        default: ;
      endcase
    end
    checkOutput("m_state", w_state, e_state);
    checkOutput("m_imem_req", w_imem_req, e_imem_req);
    checkOutput("m_ir_we", w_ir_we, e_ir_we);
    checkOutput("m_dmem_req", w_dmem_req, e_dmem_req);
    checkOutput("m_dmem_we", w_dmem_we, e_dmem_we);
    checkOutput("m_rf_we", w_rf_we, e_rf_we);
    checkOutput("m_wb_sel", w_wb_sel, e_wb_sel);
    checkOutput("m_pc_we", w_pc_we, e_pc_we);
    checkOutput("m_pc_sel", w_pc_sel, e_pc_sel);
    checkOutput("m_retire", w_retire, e_retire);
    checkOutput("m_halt", w_halt, e_halt);
    checkOutput("m_err", w_err, e_err);
  end

  initial begin
    int wbi;
    int exp1[6];
    int exp2[9];
    int cnt_req, cnt_we, bad, rets;
    wbi = SKIP ? 3 : 4;
    if (SKIP) exp1 = '{0, 1, 2, 4, 0, 1};
    else      exp1 = '{0, 1, 2, 3, 4, 0};
    exp2 = '{0, 1, 2, 3, 3, 3, 3, 4, 0};

    // Reset values and a plain ALU instruction
    applyStimulus(1, OP_I, 5'd1, 0, 1, 1);
    #3;
    checkOutput("rst_state", w_state, 0);
    checkOutput("rst_imem_req", w_imem_req, 0);
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      @(negedge w_clk);
      checkOutput("t1_state", w_state, exp1[i]);
      checkOutput("t1_retire", w_retire, i == wbi);
      checkOutput("t1_rf_we", w_rf_we, i == wbi);
      checkOutput("t1_pc_we", w_pc_we, i == wbi);
      if (i == wbi) checkOutput("t1_pc_sel", w_pc_sel, 0);
    end

    // Store with a slow data memory
    applyStimulus(1, OP_S, 5'd5, 0, 1, 0);
    doReset();
    cnt_req = 0; cnt_we = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      w_dmem_rdy = (i >= 6);
      @(negedge w_clk);
      checkOutput("t2_state", w_state, exp2[i]);
      cnt_req += int'(w_dmem_req);
      cnt_we  += int'(w_dmem_we);
      if (i == 7) begin
        checkOutput("t2_rf_we", w_rf_we, 0);
        checkOutput("t2_retire", w_retire, 1);
      end
    end
    checkOutput("t2_req_cycles", cnt_req, 4);
    checkOutput("t2_we_cycles", cnt_we, 4);

    // Branch: taken sampled in EX, then late w_tkn ignored
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, OP_B, 5'd7, 0, 1, 1);
      doReset();
      for (int i = 0; i <= wbi; i++) begin
        if (i > 0) step();
        w_tkn = (c == 0) ? (i == 2) : (i == wbi);
        @(negedge w_clk);
      end
      checkOutput("t3_pc_sel", w_pc_sel, c == 0);
      checkOutput("t3_rf_we", w_rf_we, 0);
      checkOutput("t3_pc_we", w_pc_we, 1);
    end

    // Write to the halt register
    applyStimulus(1, OP_I, 5'd30, 0, 1, 1);
    doReset();
    bad = 0;
    for (int i = 0; i <= wbi + 20; i++) begin
      if (i > 0) step();
      @(negedge w_clk);
      if (i == wbi) checkOutput("t4_wb_rf_we", w_rf_we, 1);
      if (i == wbi + 1) begin
        checkOutput("t4_state", w_state, 5);
        checkOutput("t4_halt", w_halt, 1);
      end
      if (i > wbi && (w_state != 3'd5 || !w_halt || w_imem_req || w_retire || w_rf_we)) bad++;
    end
    checkOutput("t4_halt_hold", bad, 0);

    // Instruction memory never ready: watchdog versus disabled watchdog
    applyStimulus(1, OP_I, 5'd1, 0, 0, 1);
    doReset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      @(negedge w_clk);
      if (i == 15) begin
        checkOutput("t5_state_before", w_state, 0);
        checkOutput("t5_err_before", w_err, 0);
      end
      if (i == 16) begin
        checkOutput("t5_state_after", w_state, 5);
        checkOutput("t5_err_after", w_err, 1);
      end
      if (z_state != 3'd0 || !z_imem_req || |{z_ir_we, z_dmem_req, z_dmem_we, z_rf_we,
          z_wb_sel, z_pc_we, z_pc_sel, z_retire, z_halt, z_err}) bad++;
    end
    checkOutput("t5_nowd_idle", bad, 0);

    // Reset in the middle of a load's MA
    applyStimulus(1, OP_LD, 5'd9, 0, 1, 0);
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      @(negedge w_clk);
    end
    checkOutput("t6_ma_state", w_state, 3);
    checkOutput("t6_ma_wb_sel", w_wb_sel, 1);
    #2 w_rst_n = 1'b0;
    #1;
    checkOutput("t6_async_zero", {w_state, w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_rf_we,
                w_wb_sel, w_pc_we, w_pc_sel, w_retire, w_halt, w_err}, 0);
    applyStimulus(1, OP_LD, 5'd9, 0, 0, 1);
    step();
    step();
    w_rst_n = 1'b1;
    rets = 0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      @(negedge w_clk);
      if (j == 0) begin
        checkOutput("t6_post_state", w_state, 0);
        checkOutput("t6_post_imem_req", w_imem_req, 1);
      end
      rets += int'(w_retire);
    end
    checkOutput("t6_no_retire", rets, 0);

    // Randomized traffic, checked by the model every cycle
    applyStimulus(1, OP_I, 5'd1, 0, 1, 1);
    doReset();
    for (int n = 0; n < 3000; n++) begin
      step();
      if (m_stage == 5 || $urandom_range(0, 299) == 0) begin
        w_rst_n = 1'b0;
        step();
        w_rst_n = 1'b1;
      end
      w_run      = ($urandom_range(0, 9) < 8);
      w_opcode5  = $urandom_range(0, 1) ? op_tbl[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
      w_rd       = 5'($urandom_range(0, 31));
      w_tkn      = 1'($urandom_range(0, 1));
      w_imem_rdy = ($urandom_range(0, 3) != 0);
      w_dmem_rdy = ($urandom_range(0, 9) < 7);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_mc_ctrl.md
Name: m_mc_ctrl

Overview:
Multicycle sequencer for the m_proc5 datapath (IF/ID/EX/MA/WB). Steps one instruction at a time through the stages and generates per-stage write enables, mux selects and memory request strobes. Waits on ready handshakes from the instruction and data memories and halts when the halt register is written. Lets the datapath share one ALU pass per instruction and use non-single-cycle memories.

Parameters:
HALT_REG, 30, rd index whose write ends execution (moves FSM to HALT)
WAIT_LIMIT, 16, max consecutive cycles waiting on a memory ready before error-halt; 0 disables the watchdog

Ports:
w_clk  in  1  clock, all state on posedge
w_rst_n  in  1  asynchronous active-low reset
w_run  in  1  enables fetch of the next instruction
w_opcode5  in  5  ir[6:2] of the current IR; valid from ID onward
w_rd  in  5  ir[11:7] of the current IR; valid from ID onward
w_tkn  in  1  ALU branch condition; sampled in EX
w_imem_rdy  in  1  instruction memory ready / data valid
w_dmem_rdy  in  1  data memory access complete
w_state  out  3  IF=0 ID=1 EX=2 MA=3 WB=4 HALT=5
w_imem_req  out  1  fetch request
w_ir_we  out  1  latch IR
w_dmem_req  out  1  data memory request
w_dmem_we  out  1  store strobe (qualifies w_dmem_req)
w_rf_we  out  1  register file write
w_wb_sel  out  1  1 = load data, 0 = ALU result
w_pc_we  out  1  PC update
w_pc_sel  out  1  1 = branch target, 0 = pc+4
w_retire  out  1  one-cycle pulse per completed instruction
w_halt  out  1  high in HALT
w_err  out  1  sticky watchdog error

Behaviour:
- Reset (w_rst_n=0, asynchronous): state=IF, internal regs cleared; every output forced to 0 while reset is low, including w_state. Reset mid-instruction abandons it; no enable may glitch high.
- Decode on opcode5: R=01100, S=01000, B=11000, U=00101/01101, J=11011, LD=00000; everything else is I. The ID-latched opcode5 and rd are used for the rest of the instruction.
- IF:
  - w_imem_req=w_run.
  - If w_run && w_imem_rdy: w_ir_we=1 for that cycle, then go to ID.
  - Otherwise stay in IF.
- ID: one cycle. Latch opcode5 and rd. Go to EX.
- EX: one cycle. Latch r_tkn = B & w_tkn. Go to MA.
- MA:
  - LD: w_dmem_req=1 and w_wb_sel=1 until w_dmem_rdy.
  - S: w_dmem_req=1 and w_dmem_we=1 until w_dmem_rdy.
  - LD/S: go to WB in the cycle after the one where w_dmem_rdy=1.
  - Other types: one idle cycle, then WB.
- WB:
  - w_rf_we = !S & !B; w_wb_sel=LD.
  - w_pc_we=1; w_pc_sel=r_tkn; w_retire=1.
  - If w_rf_we && rd==HALT_REG, go to HALT; else go to IF.
  - rd==0 still pulses w_rf_we; the register file ignores x0.
- HALT: w_halt=1, all other strobes 0. Exit only by reset.
- Nominal latency: 5 cycles per instruction with both readies tied high.
- w_tkn is ignored outside EX.
- Watchdog:
  - Counter increments each cycle spent in IF with w_run=1 && !w_imem_rdy, or in MA (LD/S) with !w_dmem_rdy.
  - Counter clears on any ready or state change.
  - When count reaches WAIT_LIMIT (and WAIT_LIMIT≠0): set w_err, go to HALT.
  - The counter saturates and does not wrap.
- w_run deasserted outside IF does not stall the current instruction.

Optional Feature:
Macro M_MC_CTRL_SKIP_MA_EN.
- Defined: non-LD/S instructions go EX→WB directly, giving 4 cycles per instruction; w_state never shows MA for them.
- Undefined: every instruction visits MA, giving 5 cycles per instruction.
- The watchdog, handshake rules and all WB outputs are identical in both builds.

Test Plan:
1. Reset, w_run=1, readies tied 1, addi x1 (opcode5=00100, rd=1):
   - w_state sequence 0,1,2,3,4,0.
   - w_rf_we, w_pc_we and w_retire high only in the WB cycle; w_pc_sel=0.
   - With SKIP_MA_EN: sequence 0,1,2,4,0.
2. Store (01000), w_dmem_rdy low 3 cycles then high:
   - w_dmem_req and w_dmem_we high 4 cycles, then WB.
   - w_rf_we=0 in WB.
3. bne (11000):
   - w_tkn=1 in EX → w_pc_sel=1 in WB.
   - w_tkn=0 in EX but 1 in WB → w_pc_sel=0; w_rf_we=0 in both cases.
4. addi x30 (rd=30):
   - After WB, w_state=5 and w_halt=1.
   - w_imem_req stays 0 for 20 further cycles with w_run=1.
5. w_imem_rdy held 0, WAIT_LIMIT=16: after 16 IF cycles w_err=1, w_state=5; with WAIT_LIMIT=0, stays in IF for 100 cycles and w_err stays 0.
6. Assert w_rst_n=0 mid-MA of a load:
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, w_imem_req=1 in state IF and the load never retires.
